count_ud_chain: RTL and testbench
=================================

// Module: count_ud_chain
// PURPOSE
//  Cascaded multi-digit modulo counter with up/down direction, sync clear and parallel load.
//  Successor of the single-digit ascending modulo counter; covers BCD/clock-style displays
//  (MODULO=10 per digit), timers and prescalers. Sits between control FSMs and display drivers.
//  One digit per modulo stage; carry/borrow ripples combinationally through the chain each cycle.
// PARAMETERS
//  MODULO  10                  count range per digit, 0..MODULO-1; legal range 2..65536
//  DIGITS  4                   number of cascaded digits; legal range 1..8
//  W       $clog2(MODULO)      bits per digit (derived, not overridden)
// PORTS
//  CLK       in   1         clock, rising edge
//  RST       in   1         synchronous reset, active-high
//  ENABLE    in   1         count enable; chain advances one step per enabled edge
//  UP        in   1         1 = count up, 0 = count down; sampled every cycle
//  CLEAR     in   1         synchronous clear of all digits
//  LOAD      in   1         synchronous parallel load from LOAD_VAL
//  LOAD_VAL  in   DIGITS*W  load value; digit i = LOAD_VAL[i*W +: W]; digit 0 = LSB
//  COUNT     out  DIGITS*W  current count, same packing as LOAD_VAL; registered
//  TC        out  1         combinational; 1 when all digits sit at terminal for current UP
//  WRAP      out  1         registered one-cycle pulse; chain wrapped on the previous edge
//  LOAD_ERR  out  1         registered one-cycle pulse; previous load had an out-of-range digit
// BEHAVIOUR
//  Reset (RST=1 at a rising edge): COUNT=0, WRAP=0, LOAD_ERR=0. RST overrides all other inputs.
//  Priority per edge: RST > CLEAR > LOAD > ENABLE. When no action applies, COUNT holds.
//  CLEAR: COUNT=0 and WRAP=0 on the next edge.
//  LOAD: each digit takes its LOAD_VAL field. A field >= MODULO loads 0 in that digit.
//    LOAD_ERR=1 on the next edge if any field was >= MODULO; valid fields load as given.
//  Terminal value per digit: MODULO-1 when UP=1, 0 when UP=0.
//  Step condition: digit i steps when ENABLE=1 and digits 0..i-1 all sit at terminal value.
//    Digit 0 always steps when ENABLE=1.
//  Up step: at MODULO-1 -> 0, otherwise +1. Down step: at 0 -> MODULO-1, otherwise -1.
//  TC = AND over all digits of (digit == terminal(UP)). TC ignores ENABLE; TC=1 right after
//    reset when UP=0.
//  WRAP: next-edge value = ENABLE & TC & ~LOAD & ~CLEAR & ~RST. Latency 1 cycle after the
//    wrapping edge.
//  Direction change: takes effect on the same edge it is sampled; no extra latency;
//    TC re-evaluates immediately.
//  ENABLE=0: COUNT, and therefore TC, holds; WRAP and LOAD_ERR return to 0 on the next edge.
//  Arithmetic is per digit in W bits; no digit ever holds a value >= MODULO.
//  Non-power-of-two MODULO is required to work (e.g. 6, 10, 60).
// STRUCTURE
//  Package count_pkg: terminal-value function term_val(up, modulo) and the legal-range
//    checks for MODULO and DIGITS (elaboration-time error when out of range).
//  Sub-module count_ud_digit, instantiated DIGITS times in a generate loop:
//    one W-bit digit register with step/up/clear/load inputs and an at_term output.
//  Top level: carry chain (AND of lower at_term outputs), TC reduction,
//    WRAP and LOAD_ERR registers.
// TESTING  (MODULO=10, DIGITS=3 unless stated)
//  Reset, UP=1, ENABLE=1 for 999 edges -> COUNT=9,9,9 and TC=1;
//    next edge -> 0,0,0, WRAP=1 for exactly one cycle.
//  Reset, UP=0 -> TC=1 at 0,0,0; one enabled edge -> 9,9,9, WRAP=1 next cycle;
//    next edge -> 9,9,8.
//  At 0,0,9: UP=1 step -> 0,1,0; at 0,1,0: UP=0 step -> 0,0,9; ENABLE=0 for 5 edges -> unchanged.
//  LOAD with digits (2,12,5) -> COUNT=2,0,5 and LOAD_ERR=1 for one cycle;
//    LOAD=1 with ENABLE=1 -> load wins, no step.
//  RST=1 mid-count at 4,5,6 with ENABLE=1 and LOAD=1 -> 0,0,0 next edge, WRAP=0, LOAD_ERR=0;
//    same check with CLEAR=1 and LOAD=1 -> 0,0,0.
//  MODULO=6, DIGITS=2, UP=1 from 5,5 -> 0,0 with WRAP=1;
//    MODULO=2, DIGITS=1 -> toggles 0,1,0 with TC on every count of 1.

Source files
------------

// File: rtl/count_ud_chain_pkg.sv
// Shared helpers for the cascaded up/down modulo counter:
// terminal-value function, load range check and parameter legality checks.
package count_pkg;

    localparam int MOD_MIN = 2;
    localparam int MOD_MAX = 65536;
    localparam int DIG_MIN = 1;
    localparam int DIG_MAX = 8;

    // Digit value at which a step carries (up) or borrows (down).
    function automatic int unsigned term_val(
        input logic        up,
        input int unsigned modulo
    );
        return up ? modulo - 1 : 0;
    endfunction

    function automatic logic over_range(
        input int unsigned v,
        input int unsigned modulo
    );
        return v >= modulo;
    endfunction

    function automatic logic modulo_ok(input int m);
        return (m >= MOD_MIN) && (m <= MOD_MAX);
    endfunction

    function automatic logic digits_ok(input int d);
        return (d >= DIG_MIN) && (d <= DIG_MAX);
    endfunction

endpackage

// File: rtl/count_ud_chain_if.sv
// Control/status bundle of count_ud_chain.
// master: drives ENABLE/UP/CLEAR/LOAD/LOAD_VAL, observes COUNT/TC/WRAP/LOAD_ERR.
// slave : the counter side of the same signals.
interface count_ud_chain_if #(
    parameter int DIGITS = 4,
    parameter int W      = 4
) ();
    logic                ENABLE;
    logic                UP;
    logic                CLEAR;
    logic                LOAD;
    logic [DIGITS*W-1:0] LOAD_VAL;
    logic [DIGITS*W-1:0] COUNT;
    logic                TC;
    logic                WRAP;
    logic                LOAD_ERR;

    modport master (
        output ENABLE, UP, CLEAR, LOAD, LOAD_VAL,
        input  COUNT, TC, WRAP, LOAD_ERR
    );

    modport slave (
        input  ENABLE, UP, CLEAR, LOAD, LOAD_VAL,
        output COUNT, TC, WRAP, LOAD_ERR
    );
endinterface

// File: rtl/count_ud_chain_digit.sv
// One modulo-MODULO up/down digit of the counter chain.
// Ports: clk, rst (sync, active-high), step, up, clear, load, ld_val in;
//        q (digit value), at_term (q at terminal for up), ld_bad (ld_val >= MODULO) out.
module count_ud_digit
    import count_pkg::*;
#(
    parameter int MODULO = 10,
    parameter int W      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         up,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         at_term,
    output logic         ld_bad
);

    localparam logic [W-1:0] TOP = W'(MODULO - 1);

    assign ld_bad  = over_range(32'(ld_val), MODULO);
    assign at_term = (q == W'(term_val(up, MODULO)));

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            // Out-of-range fields are forced to 0 so q stays < MODULO.
            q <= ld_bad ? '0 : ld_val;
        end else if (step) begin
            if (up) begin
                q <= (q == TOP) ? '0 : q + W'(1);
            end else begin
                q <= (q == '0) ? TOP : q - W'(1);
            end
        end
    end

endmodule

// File: rtl/count_ud_chain.sv
// Cascaded multi-digit up/down modulo counter with sync clear and parallel load.
// Ports: CLK, RST (sync, active-high); bus (slave): ENABLE, UP, CLEAR, LOAD,
//        LOAD_VAL in; COUNT, TC (comb), WRAP, LOAD_ERR (registered pulses) out.
module count_ud_chain
    import count_pkg::*;
#(
    parameter int MODULO = 10,
    parameter int DIGITS = 4
) (
    input  logic            CLK,
    input  logic            RST,
    count_ud_chain_if.slave bus
);

    localparam int W = $clog2(MODULO);

    if (!modulo_ok(MODULO)) begin : g_bad_modulo
        $error("count_ud_chain: MODULO out of range 2..65536");
    end
    if (!digits_ok(DIGITS)) begin : g_bad_digits
        $error("count_ud_chain: DIGITS out of range 1..8");
    end

    logic [DIGITS-1:0] at_term;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] ld_bad;
    logic [W-1:0]      dq [DIGITS];
    logic              tc;
    logic              wrap_q;
    logic              lerr_q;

    // carry[i]: digit i steps this edge; ripples through lower at_term.
    assign carry[0] = bus.ENABLE;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        if (i > 0) begin : g_carry
            assign carry[i] = carry[i-1] & at_term[i-1];
        end

        count_ud_digit #(
            .MODULO (MODULO),
            .W      (W)
        ) u_digit (
            .clk     (CLK),
            .rst     (RST),
            .step    (carry[i]),
            .up      (bus.UP),
            .clear   (bus.CLEAR),
            .load    (bus.LOAD),
            .ld_val  (bus.LOAD_VAL[i*W +: W]),
            .q       (dq[i]),
            .at_term (at_term[i]),
            .ld_bad  (ld_bad[i])
        );

        assign bus.COUNT[i*W +: W] = dq[i];
    end

    assign tc = &at_term;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            wrap_q <= bus.ENABLE & tc & ~bus.LOAD & ~bus.CLEAR;
            lerr_q <= bus.LOAD & ~bus.CLEAR & (|ld_bad);
        end
    end

    assign bus.TC       = tc;
    assign bus.WRAP     = wrap_q;
    assign bus.LOAD_ERR = lerr_q;

endmodule

// File: tb/tb_count_ud_chain.sv
// Self-checking bench for count_ud_chain: three configurations
// (10/3, 6/2, 2/1) against an integer reference model via a scoreboard queue.
module tb_count_ud_chain;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    count_ud_chain_if #(.DIGITS(3), .W(4)) if0 ();
    count_ud_chain_if #(.DIGITS(2), .W(3)) if1 ();
    count_ud_chain_if #(.DIGITS(1), .W(1)) if2 ();

    count_ud_chain #(.MODULO(10), .DIGITS(3)) u0 (
        .CLK (clk), .RST (rst), .bus (if0)
    );
    count_ud_chain #(.MODULO(6), .DIGITS(2)) u1 (
        .CLK (clk), .RST (rst), .bus (if1)
    );
    count_ud_chain #(.MODULO(2), .DIGITS(1)) u2 (
        .CLK (clk), .RST (rst), .bus (if2)
    );

    typedef struct {
        int          dut;
        logic [31:0] count;
        logic        tc;
        logic        wrap;
        logic        lerr;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   v  [3] = '{0, 0, 0};
    int   MD [3] = '{10, 6, 2};
    int   DG [3] = '{3, 2, 1};
    int   WD [3] = '{4, 3, 1};

    function automatic logic [31:0] pack(input int val, input int m,
                                         input int d, input int w);
        logic [31:0] p = '0;
        int t = val;
        for (int i = 0; i < d; i++) begin
            p = p | (32'(t % m) << (i * w));
            t = t / m;
        end
        return p;
    endfunction

    task automatic check(input exp_t e);
        logic [31:0] ac;
        logic atc, aw, al;
        case (e.dut)
            0: begin ac = 32'(if0.COUNT); atc = if0.TC;
                     aw = if0.WRAP; al = if0.LOAD_ERR; end
            1: begin ac = 32'(if1.COUNT); atc = if1.TC;
                     aw = if1.WRAP; al = if1.LOAD_ERR; end
            default: begin ac = 32'(if2.COUNT); atc = if2.TC;
                     aw = if2.WRAP; al = if2.LOAD_ERR; end
        endcase
        checks++;
        assert (ac === e.count) else begin
            failures++;
            $error("FAIL %s.count dut%0d got=%h exp=%h", e.tag, e.dut, ac, e.count);
        end
        checks++;
        assert (atc === e.tc) else begin
            failures++;
            $error("FAIL %s.tc dut%0d got=%b exp=%b", e.tag, e.dut, atc, e.tc);
        end
        checks++;
        assert (aw === e.wrap) else begin
            failures++;
            $error("FAIL %s.wrap dut%0d got=%b exp=%b", e.tag, e.dut, aw, e.wrap);
        end
        checks++;
        assert (al === e.lerr) else begin
            failures++;
            $error("FAIL %s.lerr dut%0d got=%b exp=%b", e.tag, e.dut, al, e.lerr);
        end
    endtask

    // One clock edge: drive DUT `sel`, idle the others, model all, compare.
    task automatic cycle(input string tag, input int sel, input logic r,
                         input logic en, input logic u, input logic c,
                         input logic l, input logic [31:0] lv);
        rst = r;
        if0.UP = u; if1.UP = u; if2.UP = u;
        if0.ENABLE = (sel == 0) & en; if0.CLEAR = (sel == 0) & c;
        if0.LOAD = (sel == 0) & l; if0.LOAD_VAL = (sel == 0) ? lv[11:0] : '0;
        if1.ENABLE = (sel == 1) & en; if1.CLEAR = (sel == 1) & c;
        if1.LOAD = (sel == 1) & l; if1.LOAD_VAL = (sel == 1) ? lv[5:0] : '0;
        if2.ENABLE = (sel == 2) & en; if2.CLEAR = (sel == 2) & c;
        if2.LOAD = (sel == 2) & l; if2.LOAD_VAL = (sel == 2) ? lv[0:0] : '0;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            int m = MD[k], d = DG[k], w = WD[k], modv = 1;
            logic ke = (sel == k) & en;
            logic kc = (sel == k) & c;
            logic kl = (sel == k) & l;
            logic tcn;
            for (int i = 0; i < d; i++) modv = modv * m;
            tcn = u ? (v[k] == modv - 1) : (v[k] == 0);
            e.dut = k; e.tag = tag; e.wrap = 1'b0; e.lerr = 1'b0;
            if (r || kc) begin
                v[k] = 0;
            end else if (kl) begin
                int nv = 0, pw = 1;
                for (int i = 0; i < d; i++) begin
                    int f = int'((lv >> (i * w)) & ((32'd1 << w) - 1));
                    if (f >= m) begin
                        f = 0;
                        e.lerr = 1'b1;
                    end
                    nv = nv + f * pw;
                    pw = pw * m;
                end
                v[k] = nv;
            end else if (ke) begin
                v[k] = u ? (v[k] + 1) % modv : (v[k] + modv - 1) % modv;
                e.wrap = tcn;
            end
            e.tc = u ? (v[k] == modv - 1) : (v[k] == 0);
            e.count = pack(v[k], m, d, w);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) check(sbq.pop_front());
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset beats enable and load.
        cycle("rst_up", 0, 1, 1, 1, 0, 1, 32'h456);
        for (int i = 0; i < 999; i++) cycle("up999", 0, 0, 1, 1, 0, 0, 0);
        cycle("wrap_up", 0, 0, 1, 1, 0, 0, 0);
        cycle("after_wrap", 0, 0, 1, 1, 0, 0, 0);
        // Down from zero.
        cycle("rst_dn", 0, 1, 0, 0, 0, 0, 0);
        cycle("wrap_dn", 0, 0, 1, 0, 0, 0, 0);
        cycle("dn998", 0, 0, 1, 0, 0, 0, 0);
        // Carry/borrow at digit boundary and hold.
        cycle("ld009", 0, 0, 0, 1, 0, 1, 32'h009);
        cycle("up010", 0, 0, 1, 1, 0, 0, 0);
        cycle("dn009", 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle("hold", 0, 0, 0, 0, 0, 0, 0);
        // Load with an out-of-range middle digit, then load vs enable.
        cycle("ld_bad", 0, 0, 0, 1, 0, 1, 32'h2C5);
        cycle("ld_en", 0, 0, 1, 1, 0, 1, 32'h345);
        cycle("idle", 0, 0, 0, 1, 0, 0, 0);
        // Reset and clear override load.
        cycle("ld456", 0, 0, 0, 1, 0, 1, 32'h456);
        cycle("rst_mid", 0, 1, 1, 1, 0, 1, 32'h123);
        cycle("ld456b", 0, 0, 0, 1, 0, 1, 32'h456);
        cycle("clr_ld", 0, 0, 1, 1, 1, 1, 32'h123);
        // Mixed direction walk on the 3-digit chain.
        for (int i = 0; i < 40; i++)
            cycle("rnd", 0, 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 0, 0, 0);
        // MODULO=6, DIGITS=2.
        cycle("m6_ld55", 1, 0, 0, 1, 0, 1, 32'h2D);
        cycle("m6_wrap", 1, 0, 1, 1, 0, 0, 0);
        cycle("m6_dn", 1, 0, 1, 0, 0, 0, 0);
        cycle("m6_dn2", 1, 0, 1, 0, 0, 0, 0);
        cycle("m6_ldbad", 1, 0, 0, 1, 0, 1, 32'h0F);
        for (int i = 0; i < 8; i++) cycle("m6_up", 1, 0, 1, 1, 0, 0, 0);
        // MODULO=2, DIGITS=1.
        for (int i = 0; i < 4; i++) cycle("m2_up", 2, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("m2_dn", 2, 0, 1, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
